// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the byte-serial ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic [3:0] OP_ADD = 4'b1001;
    localparam logic [3:0] OP_SUB = 4'b0110;

    // Arithmetic ops whose carry input is active-low (cn) need the previous carry inverted.
    function automatic logic op_uses_cn(input logic [3:0] op);
        case (op)
            4'b1000, OP_ADD, 4'b1010, 4'b1101, 4'b1110: return 1'b0;
            OP_SUB:                                     return 1'b1;
            default:                                    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_byte_sequencer.sv
// Runs one BYTES-wide ALU operation as serial 8-bit passes, LSB first, chaining carry.
// Optional ALU_SEQ_FLAGS_EN adds registered zero/sign flags of the assembled result.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EXEC  | one byte pass per cycle through the external ALU
// DONE  | result held on rsp_* until rsp_ready
module alu_byte_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [8*BYTES-1:0]   req_a,
    input  logic [8*BYTES-1:0]   req_b,
    input  logic [3:0]           req_op,
    input  logic                 req_mode,
    input  logic                 req_cf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8*BYTES-1:0]   rsp_result,
    output logic                 rsp_cf,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                 rsp_zf,
    output logic                 rsp_sf,
`endif
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic                 alu_cf_in,
    output logic [3:0]           alu_op,
    output logic                 alu_mode,
    input  logic [7:0]           alu_out,
    input  logic                 alu_cf_out
);

    localparam int W     = 8 * BYTES;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    seq_state_e       state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [3:0]       op_q;
    logic             mode_q;
    logic             cf_q;
    logic             cf_prev;
    logic [W-1:0]     result_q;
    logic             rsp_cf_q;
    logic [W-1:0]     result_next;
    logic             exec_act;
    logic             cin;

`ifdef ALU_SEQ_FLAGS_EN
    logic zf_q;
    logic sf_q;
`endif

    always_comb begin
        result_next = result_q;
        result_next[8*idx +: 8] = alu_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mode_q   <= 1'b0;
            cf_q     <= 1'b0;
            cf_prev  <= 1'b0;
            result_q <= '0;
            rsp_cf_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q    <= req_a;
                        b_q    <= req_b;
                        op_q   <= req_op;
                        mode_q <= req_mode;
                        cf_q   <= req_cf;
                        idx    <= '0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= result_next;
                    cf_prev  <= alu_cf_out;
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        rsp_cf_q <= alu_cf_out;
`ifdef ALU_SEQ_FLAGS_EN
                        zf_q     <= (result_next == '0);
                        sf_q     <= result_next[W-1];
`endif
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Logic ops reuse the request carry on every pass; arithmetic ops chain it.
    always_comb begin
        if (idx == '0 || mode_q)  cin = cf_q;
        else if (op_uses_cn(op_q)) cin = ~cf_prev;
        else                       cin = cf_prev;
    end

    assign exec_act  = (state == EXEC) && !rst;
    assign alu_a     = exec_act ? a_q[8*idx +: 8] : 8'h00;
    assign alu_b     = exec_act ? b_q[8*idx +: 8] : 8'h00;
    assign alu_op    = exec_act ? op_q : 4'h0;
    assign alu_mode  = exec_act && mode_q;
    assign alu_cf_in = exec_act && cin;

    assign req_ready  = (state == IDLE) && !rst;
    assign rsp_valid  = (state == DONE) && !rst;
    assign rsp_result = result_q;
    assign rsp_cf     = rsp_cf_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_zf     = zf_q;
    assign rsp_sf     = sf_q;
`endif

endmodule
